// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the round-robin shared-bus interconnect:
// bus widths and the arbiter state encoding.
package wb_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_ADR_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_conbus_rr_if.sv
// Bus bundle for wb_conbus_rr. The master modport is the interconnect's
// master-facing side and the slave modport is its slave-facing side. Both
// modports may be bound to the same interface instance.
interface wb_conbus_rr_if
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 6
);

  logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat_i;
  logic [NUM_MASTERS*WB_ADR_W-1:0] m_adr_i;
  logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel_i;
  logic [NUM_MASTERS-1:0]          m_we_i;
  logic [NUM_MASTERS-1:0]          m_cyc_i;
  logic [NUM_MASTERS-1:0]          m_stb_i;
  logic [WB_DAT_W-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]          m_ack_o;
  logic [NUM_MASTERS-1:0]          m_err_o;
  logic [NUM_MASTERS-1:0]          m_gnt_o;

  logic [WB_DAT_W-1:0]             s_dat_o;
  logic [WB_ADR_W-1:0]             s_adr_o;
  logic [WB_SEL_W-1:0]             s_sel_o;
  logic                            s_we_o;
  logic [NUM_SLAVES-1:0]           s_cyc_o;
  logic [NUM_SLAVES-1:0]           s_stb_o;
  logic [NUM_SLAVES*WB_DAT_W-1:0]  s_dat_i;
  logic [NUM_SLAVES-1:0]           s_ack_i;

  modport master (
    input  m_dat_i, m_adr_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    output m_dat_o, m_ack_o, m_err_o, m_gnt_o
  );

  modport slave (
    output s_dat_o, s_adr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i
  );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Registered round-robin bus arbiter. The owner keeps the bus for as long
// as its cyc stays high; on release the grant hands over on the same edge
// to the next requester after the releasing master.
//
// state       | meaning
// ARB_IDLE    | no owner, grant = 0, searching from ptr+1
// ARB_GRANTED | gnt_idx owns the bus while req[gnt_idx] is high
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   gnt_vld
);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       base;
  logic [IDX_W-1:0]       pick;
  logic                   found;

  // State, pointer and one-hot grant registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= IDX_W'(NUM_MASTERS - 1);
      idx_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
    end
  end

  // Round-robin search and next-state logic. While granted, the search
  // starts after the current owner, which is where the pointer lands on release.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    base    = (state_q == ARB_GRANTED) ? idx_q : ptr_q;
    found   = 1'b0;
    pick    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && req[i] && (IDX_W'(i) > base)) begin
        found = 1'b1;
        pick  = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && req[i] && (IDX_W'(i) <= base)) begin
        found = 1'b1;
        pick  = IDX_W'(i);
      end
    end
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d = ARB_GRANTED;
          idx_d   = pick;
          gnt_d   = NUM_MASTERS'(1) << pick;
        end
      end
      ARB_GRANTED: begin
        if (!req[idx_q]) begin
          ptr_d = idx_q;
          if (found) begin
            idx_d = pick;
            gnt_d = NUM_MASTERS'(1) << pick;
          end else begin
            state_d = ARB_IDLE;
            idx_d   = '0;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        idx_d   = '0;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = (state_q == ARB_GRANTED);

endmodule

// File: rtl/wb_conbus_rr.sv
// Parametrised shared-bus Wishbone interconnect: NUM_MASTERS masters share
// one bus to NUM_SLAVES slaves through a round-robin arbiter. The slave is
// decoded from the top S_ADDR_W address bits, and unmapped accesses get a
// one-cycle error from an internal responder.
// Optional build macro WB_TIMEOUT_EN adds a stall watchdog that errors a
// granted strobe left without ack for TIMEOUT_CYCLES cycles.
module wb_conbus_rr
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 6,
  parameter int S_ADDR_W    = 3,
  parameter logic [NUM_SLAVES*S_ADDR_W-1:0] S_ADDRS =
    {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  wb_conbus_rr_if.master mbus,
  wb_conbus_rr_if.slave  sbus
);

  localparam int MI_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SI_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [NUM_MASTERS-1:0] gnt;
  logic [MI_W-1:0]        gnt_idx;
  logic                   gnt_vld;

  logic [WB_ADR_W-1:0]    g_adr;
  logic [WB_DAT_W-1:0]    g_dat;
  logic [WB_SEL_W-1:0]    g_sel;
  logic                   g_we;
  logic                   g_cyc;
  logic                   g_stb;

  logic [SI_W-1:0]        sel_idx;
  logic                   sel_vld;
  logic                   hit;
  logic                   slv_ack;
  logic                   unmapped;

  logic                   err_q;
  logic [MI_W-1:0]        err_idx_q;
  logic                   err_hit;
  logic                   to_err;

  wb_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_arb (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .req     (mbus.m_cyc_i),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign mbus.m_gnt_o = gnt;

  // Mux the granted master onto the shared bus; all zero with no owner
  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    if (gnt_vld) begin
      g_adr = mbus.m_adr_i[gnt_idx*WB_ADR_W +: WB_ADR_W];
      g_dat = mbus.m_dat_i[gnt_idx*WB_DAT_W +: WB_DAT_W];
      g_sel = mbus.m_sel_i[gnt_idx*WB_SEL_W +: WB_SEL_W];
      g_we  = mbus.m_we_i[gnt_idx];
      g_cyc = mbus.m_cyc_i[gnt_idx];
      g_stb = mbus.m_stb_i[gnt_idx];
    end
  end

  assign sbus.s_adr_o = g_adr;
  assign sbus.s_dat_o = g_dat;
  assign sbus.s_sel_o = g_sel;
  assign sbus.s_we_o  = g_we;

  // Address decode; scanning downward leaves the lowest matching slave
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (g_adr[WB_ADR_W-1 -: S_ADDR_W] == S_ADDRS[i*S_ADDR_W +: S_ADDR_W]) begin
        sel_vld = 1'b1;
        sel_idx = SI_W'(i);
      end
    end
  end

  assign hit      = gnt_vld & sel_vld;
  assign unmapped = gnt_vld & g_cyc & g_stb & ~sel_vld;
  assign slv_ack  = hit & g_stb & sbus.s_ack_i[sel_idx];

  // Per-slave cycle and strobe for the decoded slave only
  always_comb begin
    sbus.s_cyc_o = '0;
    sbus.s_stb_o = '0;
    if (hit) begin
      sbus.s_cyc_o[sel_idx] = g_cyc;
      sbus.s_stb_o[sel_idx] = g_stb;
    end
  end

  assign mbus.m_dat_o = hit ? sbus.s_dat_i[sel_idx*WB_DAT_W +: WB_DAT_W] : '0;

  // Unmapped-access responder: one err per beat, one cycle after the strobe.
  // The owner is remembered so a grant handover never receives a stale err.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      err_q     <= unmapped & ~err_q;
      err_idx_q <= gnt_idx;
    end
  end

  assign err_hit = err_q & gnt_vld & (err_idx_q == gnt_idx);

`ifdef WB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;

  assign to_err = gnt_vld & g_cyc & g_stb & (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

  // Stall watchdog: counts strobe cycles that have no response yet
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      to_cnt_q <= '0;
    end else if (!(gnt_vld && g_cyc && g_stb) || slv_ack || err_hit || to_err) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign to_err = 1'b0;
`endif

  // Route ack and err to the bus owner only
  always_comb begin
    mbus.m_ack_o = '0;
    mbus.m_err_o = '0;
    if (gnt_vld) begin
      mbus.m_ack_o[gnt_idx] = slv_ack;
      mbus.m_err_o[gnt_idx] = err_hit | to_err;
    end
  end

endmodule
